// File: rtl/synaptic_current_accumulator_if.sv
// Purpose: bundles the spike-vector handshake and the current result bus
//          between the presynaptic source, the accumulator and the neuron.
// Signals:
//   spike_in       presynaptic spike vector, bit i = input i fired
//   spike_valid    spike_in/weights valid this cycle
//   spike_ready    accumulator can accept a vector
//   weights        flat signed weight bus, weight i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   input_current  saturated signed sum, held between pulses
//   current_valid  one-cycle pulse, input_current updated this cycle
//   saturated      pulse aligned with current_valid, 1 = sum was clipped
//   busy           accumulator is summing or presenting a result
// Modports: master = upstream/neuron side, slave = accumulator side.
interface synaptic_current_accumulator_if #(
    parameter int NUM_INPUTS   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CUR_WIDTH    = 5
);
    logic [NUM_INPUTS-1:0]              spike_in;
    logic                               spike_valid;
    logic                               spike_ready;
    logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights;
    logic [CUR_WIDTH-1:0]               input_current;
    logic                               current_valid;
    logic                               saturated;
    logic                               busy;

    modport master (
        output spike_in, spike_valid, weights,
        input  spike_ready, input_current, current_valid, saturated, busy
    );

    modport slave (
        input  spike_in, spike_valid, weights,
        output spike_ready, input_current, current_valid, saturated, busy
    );
endinterface

// File: rtl/synaptic_current_accumulator.sv
// Purpose: upstream stage of the LIF neuron. Takes one spike vector per
//          timestep, serially sums the signed weights of the active inputs
//          (one input per cycle), saturates the sum to the neuron's signed
//          current range and presents it with a one-cycle current_valid pulse.
// Ports:
//   clk    clock, all state on rising edge
//   reset  asynchronous reset, active-high
//   bus    slave side of synaptic_current_accumulator_if (handshake + result)
module synaptic_current_accumulator #(
    parameter int NUM_INPUTS   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CUR_WIDTH    = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    synaptic_current_accumulator_if.slave   bus
);

    // One guard bit beyond the worst-case sum so the accumulator never wraps.
    localparam int ACC_W = WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int WB_W  = NUM_INPUTS * WEIGHT_WIDTH;

    localparam logic signed [ACC_W-1:0] CUR_MAX = ACC_W'((2 ** (CUR_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] CUR_MIN = -ACC_W'(2 ** (CUR_WIDTH - 1));
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_INPUTS-1:0]     spikes_q, spikes_d;
    logic [WB_W-1:0]           weights_q, weights_d;
    logic [CUR_WIDTH-1:0]      current_q, current_d;
    logic                      valid_q, valid_d;
    logic                      sat_q, sat_d;

    logic [WEIGHT_WIDTH-1:0]   weight_sel;
    logic signed [ACC_W-1:0]   weight_ext;

    // Weight of the input being visited this cycle, sign-extended to the
    // accumulator width.
    always_comb begin
        weight_sel = weights_q[idx_q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        weight_ext = {{(ACC_W-WEIGHT_WIDTH){weight_sel[WEIGHT_WIDTH-1]}}, weight_sel};
    end

    // Next-state and datapath logic. The result registers only change on the
    // edge leaving OUT, so input_current holds its value between pulses.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        spikes_d  = spikes_q;
        weights_d = weights_q;
        current_d = current_q;
        valid_d   = 1'b0;
        sat_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.spike_valid) begin
                    // Snapshot the inputs so upstream may change them mid-sum.
                    spikes_d  = bus.spike_in;
                    weights_d = bus.weights;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (spikes_q[idx_q]) begin
                    acc_d = acc_q + weight_ext;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                valid_d = 1'b1;
                state_d = IDLE;
                if (acc_q > CUR_MAX) begin
                    current_d = {1'b0, {(CUR_WIDTH-1){1'b1}}};
                    sat_d     = 1'b1;
                end else if (acc_q < CUR_MIN) begin
                    current_d = {1'b1, {(CUR_WIDTH-1){1'b0}}};
                    sat_d     = 1'b1;
                end else begin
                    current_d = acc_q[CUR_WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any in-flight sum without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            spikes_q  <= '0;
            weights_q <= '0;
            current_q <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            spikes_q  <= spikes_d;
            weights_q <= weights_d;
            current_q <= current_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.spike_ready   = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.input_current = current_q;
    assign bus.current_valid = valid_q;
    assign bus.saturated     = sat_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Purpose: directed self-checking bench for synaptic_current_accumulator.
//          Each scenario task drives vectors and compares outputs against
//          hand-computed values; a summary line reports the totals.
module tb_synaptic_current_accumulator;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    synaptic_current_accumulator_if #(.NUM_INPUTS(8), .WEIGHT_WIDTH(4), .CUR_WIDTH(5)) bus ();

    synaptic_current_accumulator #(
        .NUM_INPUTS  (8),
        .WEIGHT_WIDTH(4),
        .CUR_WIDTH   (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one vector for exactly one accept edge, then scramble the
    // inputs so any late sampling would corrupt the result.
    task automatic send(input logic [7:0] s, input logic [31:0] w);
        @(negedge clk);
        bus.spike_in    = s;
        bus.weights     = w;
        bus.spike_valid = 1'b1;
        @(negedge clk);
        bus.spike_valid = 1'b0;
        bus.spike_in    = ~s;
        bus.weights     = ~w;
    endtask

    // Counts negedges from the first cycle after the accept edge until the
    // pulse is seen; returns 0 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!bus.current_valid && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.current_valid) cycles = 0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.spike_valid = 1'b0;
        bus.spike_in    = '0;
        bus.weights     = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.spike_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL reset_ctrl: got ready=%b busy=%b expected ready=1 busy=0",
                     bus.spike_ready, bus.busy);
            miscompares++;
        end
        vectors++;
        if (bus.input_current !== 5'd0 || bus.current_valid !== 1'b0 || bus.saturated !== 1'b0) begin
            $display("[TB] FAIL reset_out: got cur=%b valid=%b sat=%b expected 00000 0 0",
                     bus.input_current, bus.current_valid, bus.saturated);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        vectors++;
        if (bus.spike_ready !== 1'b1) begin
            $display("[TB] FAIL basic_ready: got %b expected 1", bus.spike_ready);
            miscompares++;
        end
        send(8'b0000_0101, 32'h7777_7F73);
        vectors++;
        if (bus.busy !== 1'b1 || bus.spike_ready !== 1'b0) begin
            $display("[TB] FAIL basic_busy: got busy=%b ready=%b expected busy=1 ready=0",
                     bus.busy, bus.spike_ready);
            miscompares++;
        end
        wait_valid(cyc);
        vectors++;
        if (cyc !== 10) begin
            $display("[TB] FAIL basic_latency: got %0d cycles expected 10", cyc);
            miscompares++;
        end
        vectors++;
        if (bus.input_current !== 5'd2 || bus.saturated !== 1'b0) begin
            $display("[TB] FAIL basic_result: got cur=%b sat=%b expected 00010 0",
                     bus.input_current, bus.saturated);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.current_valid !== 1'b0 || bus.input_current !== 5'd2 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL basic_hold: got valid=%b cur=%b busy=%b expected 0 00010 0",
                     bus.current_valid, bus.input_current, bus.busy);
            miscompares++;
        end
    endtask

    task automatic test_pos_sat();
        int cyc;
        send(8'hFF, 32'h7777_7777);
        wait_valid(cyc);
        vectors++;
        if (cyc !== 10 || bus.input_current !== 5'b01111 || bus.saturated !== 1'b1) begin
            $display("[TB] FAIL pos_sat: got cyc=%0d cur=%b sat=%b expected 10 01111 1",
                     cyc, bus.input_current, bus.saturated);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.saturated !== 1'b0 || bus.input_current !== 5'b01111) begin
            $display("[TB] FAIL pos_sat_pulse: got sat=%b cur=%b expected 0 01111",
                     bus.saturated, bus.input_current);
            miscompares++;
        end
    endtask

    task automatic test_neg_sat();
        int cyc;
        send(8'hFF, 32'h8888_8888);
        wait_valid(cyc);
        vectors++;
        if (cyc !== 10 || bus.input_current !== 5'b10000 || bus.saturated !== 1'b1) begin
            $display("[TB] FAIL neg_sat: got cyc=%0d cur=%b sat=%b expected 10 10000 1",
                     cyc, bus.input_current, bus.saturated);
            miscompares++;
        end
        send(8'h03, 32'h7777_7788);
        wait_valid(cyc);
        vectors++;
        if (cyc !== 10 || bus.input_current !== 5'b10000 || bus.saturated !== 1'b0) begin
            $display("[TB] FAIL neg_edge: got cyc=%0d cur=%b sat=%b expected 10 10000 0",
                     cyc, bus.input_current, bus.saturated);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_accum();
        bit pulsed;
        send(8'hFF, 32'h7777_7777);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.spike_ready !== 1'b1 || bus.busy !== 1'b0 || bus.input_current !== 5'd0) begin
            $display("[TB] FAIL mid_reset: got ready=%b busy=%b cur=%b expected 1 0 00000",
                     bus.spike_ready, bus.busy, bus.input_current);
            miscompares++;
        end
        reset  = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.current_valid) pulsed = 1'b1;
        end
        vectors++;
        if (pulsed !== 1'b0) begin
            $display("[TB] FAIL mid_reset_pulse: got pulse=%b expected 0", pulsed);
            miscompares++;
        end
    endtask

    // spike_valid held high with a new vector every cycle; only vectors
    // present at IDLE edges (every 10 cycles) are accepted. Weights of +1
    // make each result the popcount of the accepted vector.
    task automatic test_back_to_back();
        logic [7:0] pat [0:30];
        for (int j = 0; j <= 30; j++) pat[j] = 8'(j * 37 + 5);
        bus.weights     = 32'h1111_1111;
        bus.spike_valid = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            bus.spike_in = pat[j];
            vectors++;
            if (j > 0 && j % 10 == 0) begin
                if (bus.current_valid !== 1'b1 ||
                    bus.input_current !== 5'($countones(pat[j-10]))) begin
                    $display("[TB] FAIL b2b_pulse[%0d]: got valid=%b cur=%0d expected 1 %0d",
                             j, bus.current_valid, bus.input_current, $countones(pat[j-10]));
                    miscompares++;
                end
            end else begin
                if (bus.current_valid !== 1'b0) begin
                    $display("[TB] FAIL b2b_idle[%0d]: got valid=%b expected 0",
                             j, bus.current_valid);
                    miscompares++;
                end
            end
            @(negedge clk);
        end
        bus.spike_valid = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_empty();
        int cyc;
        send(8'h00, 32'h8888_8888);
        wait_valid(cyc);
        vectors++;
        if (cyc !== 10 || bus.input_current !== 5'd0 || bus.saturated !== 1'b0) begin
            $display("[TB] FAIL empty: got cyc=%0d cur=%b sat=%b expected 10 00000 0",
                     cyc, bus.input_current, bus.saturated);
            miscompares++;
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        $display("[TB] starting synaptic_current_accumulator bench");
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_reset_mid_accum();
        test_back_to_back();
        test_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
